// File: rtl/mrsw_rdata.sv
// mrsw_rdata: multi-read, single-write RAM with registered read data.
//
// READ_PORTS independent synchronous read ports and one byte-strobed
// write port over a 2**ADDR_WIDTH x DATA_WIDTH array. The array is never
// cleared by reset. Only the per-port read-data flops reset, and they
// reset asynchronously.
//
// Optional build macro:
//   MRSW_RDATA_BYPASS_EN  defined   -> write-first: a read that collides with
//                                     a write at the same edge returns the
//                                     byte-merged post-write word.
//                         undefined -> read-first: the colliding read returns
//                                     the old word.

module mrsw_rdata #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2,
  parameter int READ_PORTS = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             wen,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [DATA_WIDTH/8-1:0]          wstrb,
  input  logic [READ_PORTS-1:0]            ren,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] raddr,
  output logic [READ_PORTS*DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH / 8;

  // The declaration initialiser gives the power-up (time 0) zero contents.
  // Reset deliberately has no effect on the array.
  logic [DATA_WIDTH-1:0] mem_r [DEPTH] = '{default: '0};

`ifdef MRSW_RDATA_BYPASS_EN
  // Byte merge: strobed bytes come from the new data and the rest from
  // the old word.
  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NBYTES-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < NBYTES; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction
`endif

  // Byte-strobed write into the array. Writes still happen while reset is high.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (wen && wstrb[i]) begin
        mem_r[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [DATA_WIDTH-1:0] word_s;
    logic [DATA_WIDTH-1:0] rd_r;

    assign addr_s = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];

    // Select the word this port loads: the old array word, or the
    // write-merged word when the read collides with a write.
    always_comb begin
      word_s = mem_r[addr_s];
`ifdef MRSW_RDATA_BYPASS_EN
      if (wen && (waddr == addr_s)) begin
        word_s = byte_merge(mem_r[addr_s], wdata, wstrb);
      end else begin
        word_s = mem_r[addr_s];
      end
`endif
    end

    // Read-data register. It clears on reset, loads on ren and otherwise holds.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        rd_r <= '0;
      end else if (ren[p]) begin
        rd_r <= word_s;
      end
    end

    assign rdata[p*DATA_WIDTH +: DATA_WIDTH] = rd_r;
  end

endmodule

// File: tb/tb_mrsw_rdata.sv
// Self-checking bench for mrsw_rdata with default parameters (32x4, 2 ports).
// A behavioural model pushes the expected rdata onto a queue at every edge.
// Each test task pops that value after the edge and compares it with the DUT.
// The test-plan constants are also checked directly.

module tb_mrsw_rdata;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wen   = 1'b0;
  logic [1:0]  waddr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic [1:0]  ren   = 2'd0;
  logic [3:0]  raddr = 4'd0;
  logic [63:0] rdata;

  bit          clk_run = 1'b1;
  int          checks  = 0;
  int          errors  = 0;

  logic [63:0] exp_q [$];
  logic [31:0] m_mem [4] = '{default: 32'd0};
  logic [63:0] m_rd  = 64'd0;

  mrsw_rdata #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .READ_PORTS(2)) dut (
    .clock(clock), .reset(reset), .wen(wen), .waddr(waddr), .wdata(wdata),
    .wstrb(wstrb), .ren(ren), .raddr(raddr), .rdata(rdata)
  );

  // Gated clock: when clk_run is low the clock holds its current level.
  always begin
    #5;
    if (clk_run) clock = ~clock;
  end

  // Wait one rising edge, update the model with the held inputs and queue the expected rdata.
  task automatic tick();
    logic [31:0] w;
    logic [1:0]  a;
    @(posedge clock);
    for (int p = 0; p < 2; p++) begin
      if (reset) begin
        m_rd[p*32 +: 32] = 32'd0;
      end else if (ren[p]) begin
        a = raddr[p*2 +: 2];
        w = m_mem[a];
`ifdef MRSW_RDATA_BYPASS_EN
        if (wen && waddr == a)
          for (int i = 0; i < 4; i++)
            if (wstrb[i]) w[8*i +: 8] = wdata[8*i +: 8];
`endif
        m_rd[p*32 +: 32] = w;
      end
    end
    if (wen)
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) m_mem[waddr][8*i +: 8] = wdata[8*i +: 8];
    exp_q.push_back(m_rd);
    #1;
  endtask

  task automatic test_reset();
    logic [63:0] e;
    #2;
    reset = 1'b1;
    m_rd  = 64'd0;
    #1;
    checks++;
    if (rdata !== 64'd0) begin
      errors++;
      $display("FAIL reset_async got %h exp %h", rdata, 64'd0);
    end
    wen = 1'b1; waddr = 2'd1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    ren = 2'b01; raddr = {2'd0, 2'd1};
    tick();
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e || rdata !== 64'd0) begin
      errors++;
      $display("FAIL reset_hold got %h exp %h", rdata, 64'd0);
    end
    reset = 1'b0; wen = 1'b0;
    ren = 2'b11; raddr = {2'd2, 2'd1};
    tick();
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e || rdata !== {32'd0, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL reset_then_read got %h exp %h", rdata, {32'd0, 32'hDEADBEEF});
    end
  endtask

  task automatic test_strobe();
    logic [63:0] e;
    ren = 2'b00;
    wen = 1'b1; waddr = 2'd2; wdata = 32'h11223344; wstrb = 4'hF;
    tick(); void'(exp_q.pop_front());
    wdata = 32'hAABBCCDD; wstrb = 4'b0101;
    tick(); void'(exp_q.pop_front());
    wen = 1'b0; ren = 2'b01; raddr = {2'd0, 2'd2};
    tick();
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e || rdata[31:0] !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL byte_strobe got %h exp %h", rdata[31:0], 32'h11BB33DD);
    end
  endtask

  task automatic test_hold();
    logic [63:0] e;
    ren = 2'b00;
    wen = 1'b1; wstrb = 4'hF; waddr = 2'd0; wdata = 32'h5;
    tick(); void'(exp_q.pop_front());
    waddr = 2'd3; wdata = 32'h7;
    tick(); void'(exp_q.pop_front());
    wen = 1'b0; ren = 2'b11; raddr = {2'd3, 2'd0};
    tick();
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e || rdata !== {32'h7, 32'h5}) begin
      errors++;
      $display("FAIL hold_read got %h exp %h", rdata, {32'h7, 32'h5});
    end
    ren = 2'b00; wen = 1'b1; waddr = 2'd0; wdata = 32'h99;
    tick();
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e || rdata !== {32'h7, 32'h5}) begin
      errors++;
      $display("FAIL hold_1 got %h exp %h", rdata, {32'h7, 32'h5});
    end
    waddr = 2'd3; wdata = 32'h88;
    tick();
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e || rdata !== {32'h7, 32'h5}) begin
      errors++;
      $display("FAIL hold_2 got %h exp %h", rdata, {32'h7, 32'h5});
    end
    wen = 1'b0; ren = 2'b11;
    tick();
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e || rdata !== {32'h88, 32'h99}) begin
      errors++;
      $display("FAIL hold_reread got %h exp %h", rdata, {32'h88, 32'h99});
    end
  endtask

  task automatic test_collision();
    logic [63:0] e;
    logic [31:0] c;
`ifdef MRSW_RDATA_BYPASS_EN
    c = 32'hCAFEABCD;
`else
    c = 32'hCAFE0000;
`endif
    ren = 2'b00; wen = 1'b1; waddr = 2'd1; wdata = 32'hCAFE0000; wstrb = 4'hF;
    tick(); void'(exp_q.pop_front());
    wdata = 32'h1234ABCD; wstrb = 4'b0011; ren = 2'b11; raddr = {2'd1, 2'd1};
    tick();
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e || rdata !== {c, c}) begin
      errors++;
      $display("FAIL collision got %h exp %h", rdata, {c, c});
    end
    wen = 1'b0;
    tick();
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e || rdata !== {32'hCAFEABCD, 32'hCAFEABCD}) begin
      errors++;
      $display("FAIL after_collision got %h exp %h", rdata, {32'hCAFEABCD, 32'hCAFEABCD});
    end
  endtask

  task automatic test_reset_during_read();
    logic [63:0] e;
    ren = 2'b01; raddr = {2'd0, 2'd3};
    wen = 1'b1; waddr = 2'd2; wdata = 32'h55667788; wstrb = 4'hF;
    reset = 1'b1; m_rd = 64'd0;
    #1;
    checks++;
    if (rdata !== 64'd0) begin
      errors++;
      $display("FAIL rdr_async got %h exp %h", rdata, 64'd0);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e || rdata !== 64'd0) begin
      errors++;
      $display("FAIL rdr_edge got %h exp %h", rdata, 64'd0);
    end
    reset = 1'b0; wen = 1'b0; ren = 2'b11; raddr = {2'd2, 2'd3};
    tick();
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e || rdata !== {32'h55667788, 32'h88}) begin
      errors++;
      $display("FAIL rdr_after got %h exp %h", rdata, {32'h55667788, 32'h88});
    end
  endtask

  task automatic test_random();
    logic [63:0] e;
    for (int n = 0; n < 500; n++) begin
      wen   = 1'($urandom_range(0, 1));
      waddr = 2'($urandom_range(0, 3));
      wdata = $urandom;
      wstrb = 4'($urandom_range(0, 15));
      ren   = 2'($urandom_range(0, 3));
      raddr = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) begin
        clk_run = 1'b0;
        #23;
        checks++;
        if (rdata !== m_rd) begin
          errors++;
          $display("FAIL rand_pause n=%0d got %h exp %h", n, rdata, m_rd);
        end
        clk_run = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        m_rd  = 64'd0;
        #1;
        checks++;
        if (rdata !== 64'd0) begin
          errors++;
          $display("FAIL rand_async_reset n=%0d got %h exp %h", n, rdata, 64'd0);
        end
      end else begin
        reset = 1'b0;
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (rdata !== e) begin
        errors++;
        $display("FAIL rand n=%0d got %h exp %h", n, rdata, e);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_strobe();
    test_hold();
    test_collision();
    test_reset_during_read();
    test_random();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL queue_drain got %0d exp %0d", exp_q.size(), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
